sort_result_collector: RTL and testbench
========================================

# sort_result_collector

Downstream consumer of the `sort` block's output stream. It samples every word presented while the sorter's `active_output` is high, one frame per sort pass, and checks the frame is non-decreasing. It extracts min, max, median, count and sum, and holds them for the next stage behind a valid/ready handshake. It is the first block after `sort` in the processing chain.

## Interface

- `SIZE`, 1024: nominal words per frame; must match the upstream `sort` instance.
- `WIDTH`, 12: data word width; must match the upstream `sort` instance.
- `CW`, derived = `$clog2(SIZE+1)`: count width.
- `SUMW`, derived = `WIDTH + $clog2(SIZE)`: sum width.

Ports:

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `d`  in  WIDTH  sorted word, driven from `sort.q`.
- `active_output`  in  1  word on `d` valid this cycle, driven from `sort.active_output`.
- `result_valid`  out  1  result fields are valid and stable.
- `result_ready`  in  1  downstream accepts the result.
- `res_min`  out  WIDTH  first word of the frame.
- `res_max`  out  WIDTH  largest word seen in the frame.
- `res_median`  out  WIDTH  word at 0-based index SIZE/2.
- `res_count`  out  CW  words sampled.
- `res_sum`  out  SUMW  sum of the words sampled.
- `order_error`  out  1  some word was smaller than its predecessor.
- `short_frame`  out  1  `res_count` < SIZE.
- `overrun`  out  1  a frame start was missed since the last accepted result.

## Operation

- Registered `act_d` holds last cycle's `active_output`. `act_d` resets to 1, so a frame already in progress when reset is released is ignored.
- Frame start condition: `active_output & ~act_d`.
- States:
  - IDLE:
    - On the start condition: sample `d` as word 0. Set min, max and prev to `d`; count=1; sum=`d`; order_error=0. If SIZE/2==0, set median to `d`.
    - Go to COLLECT, or go straight to HOLD if SIZE==1.
  - COLLECT, `active_output`=1:
    - Sample `d` at index count.
    - If `d` < prev, set order_error.
    - max = larger of max and `d`; prev=`d`; sum+=`d`; count+=1.
    - If index==SIZE/2, median=`d`.
    - If the new count==SIZE, go to HOLD.
  - COLLECT, `active_output`=0: go to HOLD with no sample.
  - HOLD:
    - `result_valid`=1 and all `res_*` are frozen.
    - On `result_valid & result_ready`: go to IDLE and clear `overrun`.
    - Words arriving in HOLD are discarded.
    - A start condition seen in HOLD sets `overrun` (sticky). That includes the handshake cycle itself.
- Words beyond SIZE while `active_output` stays high: discarded. No error is flagged.
- `short_frame` = (count < SIZE), evaluated on entry to HOLD.
- If the median index is never reached, `res_median`=0.
- Comparisons are unsigned.
- `sum` cannot overflow within SIZE words of WIDTH bits.

## Timing

- Reset values: `result_valid`=0, all `res_*`=0, `order_error`=0, `short_frame`=0, `overrun`=0, state IDLE.
- Reset mid-frame aborts the frame. No result is produced.
- Full frame: the SIZE-th word is sampled at edge k, and `result_valid` is high after edge k.
- Truncated frame: `active_output` is sampled low at edge k, and `result_valid` is high after edge k.
- Handshake completes at the edge where `result_valid & result_ready`. `result_valid` is low after that edge.
- Earliest next frame start is the edge after the handshake edge.
- Throughput: one word per clock; no backpressure toward `sort`.

## Configuration

- `SORT_COLLECTOR_SUM_EN`
  - Defined: the sum accumulator is built and `res_sum` is driven as specified.
  - Undefined: no accumulator is instantiated and `res_sum` is tied to 0. All other behaviour is identical.

## Test plan

- SIZE=8, WIDTH=12; frame 3,5,5,9,10,20,30,4000; ready held high:
  - Expected: min=3, max=4000, median=10, count=8, sum=4082, order_error=0, short_frame=0.
  - `result_valid` is high for exactly 1 cycle.
- SIZE=8; frame 1,2,7,6,8,9,9,9:
  - Expected: order_error=1, max=9, median=8.
- SIZE=8; `active_output` drops after 3 words 4,5,6:
  - Expected: count=3, short_frame=1, median=0, sum=15.
- SIZE=8; ready held low; a second frame starts while in HOLD:
  - First result stays stable and `overrun`=1.
  - After ready pulses, `overrun`=0 and the next frame collects normally.
- Assert `rst` mid-frame after 4 words while `active_output` stays high, then release:
  - Expected: no `result_valid` for that frame; the next rising `active_output` collects a full, correct frame.
- Build without `SORT_COLLECTOR_SUM_EN` and rerun scenario 1:
  - Expected: `res_sum`=0 and all other fields unchanged.

Source files
------------

// File: rtl/sort_result_collector.sv
// Collects one sorted frame from the sort block and reports min/max/median/count/sum plus order checks.
// Optional sum accumulator is built only when SORT_COLLECTOR_SUM_EN is defined; otherwise res_sum is 0.
module sort_result_collector #(
  parameter int SIZE  = 1024,
  parameter int WIDTH = 12,
  parameter int CW    = $clog2(SIZE + 1),
  parameter int SUMW  = WIDTH + $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             active_output,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] res_min,
  output logic [WIDTH-1:0] res_max,
  output logic [WIDTH-1:0] res_median,
  output logic [CW-1:0]    res_count,
  output logic [SUMW-1:0]  res_sum,
  output logic             order_error,
  output logic             short_frame,
  output logic             overrun,
  output logic [1:0]       state_dbg
);

  // Handshake: a result is transferred at the posedge where result_valid & result_ready;
  // result_valid never drops and res_* never change until that edge.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] MED_C  = CW'(SIZE / 2);

  state_t           state, state_nxt;
  logic             act_d;
  logic             start;
  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    count_inc;

  assign start        = active_output & ~act_d;
  assign count_inc    = res_count + CW'(1);
  assign result_valid = (state == HOLD);
  assign state_dbg    = state;

  // act_d resets high so a frame already running when reset releases is not mistaken for a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) act_d <= 1'b1;
    else     act_d <= active_output;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (SIZE == 1) ? HOLD : COLLECT;
      COLLECT: if (!active_output || count_inc == SIZE_C) state_nxt = HOLD;
      HOLD:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_min     <= '0;
      res_max     <= '0;
      res_median  <= '0;
      res_count   <= '0;
      prev        <= '0;
      order_error <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          res_min     <= d;
          res_max     <= d;
          prev        <= d;
          res_count   <= CW'(1);
          order_error <= 1'b0;
          res_median  <= (SIZE / 2 == 0) ? d : '0;
          short_frame <= (CW'(1) < SIZE_C);
        end
        COLLECT: begin
          if (active_output) begin
            if (d < prev)    order_error <= 1'b1;
            if (d > res_max) res_max     <= d;
            if (res_count == MED_C) res_median <= d;
            prev        <= d;
            res_count   <= count_inc;
            short_frame <= (count_inc < SIZE_C);
          end else begin
            short_frame <= (res_count < SIZE_C);
          end
        end
        default: ;
      endcase
    end
  end

  // A start seen in HOLD (handshake cycle included) wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (state == HOLD) begin
      if (start)             overrun <= 1'b1;
      else if (result_ready) overrun <= 1'b0;
    end
  end

`ifdef SORT_COLLECTOR_SUM_EN
  logic [SUMW-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state == IDLE && start) begin
      sum_q <= SUMW'(d);
    end else if (state == COLLECT && active_output) begin
      sum_q <= sum_q + SUMW'(d);
    end
  end

  assign res_sum = sum_q;
`else
  assign res_sum = '0;
`endif

endmodule

// File: tb/tb_sort_result_collector.sv
// Randomized scoreboard bench for sort_result_collector (SIZE=8, WIDTH=12) with directed corner frames.
module tb_sort_result_collector;
  localparam int SIZE  = 8;
  localparam int WIDTH = 12;
  localparam int CW    = 4;
  localparam int SUMW  = 15;
  localparam int RW    = 3 * WIDTH + CW + SUMW + 3;

  logic             clk, rst;
  logic [WIDTH-1:0] d;
  logic             active_output, result_valid, result_ready;
  logic [WIDTH-1:0] res_min, res_max, res_median;
  logic [CW-1:0]    res_count;
  logic [SUMW-1:0]  res_sum;
  logic             order_error, short_frame, overrun;
  logic [1:0]       state_dbg;

  sort_result_collector #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .d(d), .active_output(active_output),
    .result_valid(result_valid), .result_ready(result_ready),
    .res_min(res_min), .res_max(res_max), .res_median(res_median),
    .res_count(res_count), .res_sum(res_sum), .order_error(order_error),
    .short_frame(short_frame), .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  int unsigned   cur_w[$];
  int            ready_mode = 2;  // 0 random, 1 high, 2 low
  int            valid_len  = 0;

  function automatic logic [RW-1:0] pack(input logic [WIDTH-1:0] mn, input logic [WIDTH-1:0] mx,
                                         input logic [WIDTH-1:0] md, input logic [CW-1:0] c,
                                         input logic [SUMW-1:0] s, input logic oe,
                                         input logic sf, input logic ov);
    return {mn, mx, md, c, s, oe, sf, ov};
  endfunction

  function automatic logic [RW-1:0] actual();
    return {res_min, res_max, res_median, res_count, res_sum, order_error, short_frame, overrun};
  endfunction

  function automatic int unsigned sum_or_zero(input int unsigned s);
`ifdef SORT_COLLECTOR_SUM_EN
    return s;
`else
    return 0 * s;
`endif
  endfunction

  // Frame-level reference: first SIZE words count, median is word SIZE/2 if reached.
  function automatic logic [RW-1:0] model();
    int n = (cur_w.size() > SIZE) ? SIZE : cur_w.size();
    int unsigned mx = 0, sum = 0, md = 0;
    logic oe = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (cur_w[i] > mx) mx = cur_w[i];
      sum += cur_w[i];
      if (i > 0 && cur_w[i] < cur_w[i-1]) oe = 1'b1;
    end
    if (n > SIZE / 2) md = cur_w[SIZE/2];
    return pack(WIDTH'(cur_w[0]), WIDTH'(mx), WIDTH'(md), CW'(n),
                SUMW'(sum_or_zero(sum)), oe, (n < SIZE), 1'b0);
  endfunction

  function automatic void check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endfunction

  // ready driver
  initial begin
    result_ready = 1'b0;
    forever begin
      @(negedge clk);
      result_ready = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // monitor: pops on each new result, then checks the fields stay frozen while valid
  initial begin
    logic prev_valid = 1'b0;
    logic [RW-1:0] snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (result_valid && !prev_valid) begin
          valid_len = 1;
          snap = actual();
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result got %h expected none", snap);
          end else begin
            check("result", snap, exp_q.pop_front());
          end
        end else if (result_valid) begin
          valid_len++;
          check("stable", {actual() >> 1, 1'b0}, {snap >> 1, 1'b0});
        end
        prev_valid = result_valid;
      end
    end
  end

  task automatic send_words();
    foreach (cur_w[i]) begin
      @(negedge clk);
      active_output = 1'b1;
      d = WIDTH'(cur_w[i]);
    end
    @(negedge clk);
    active_output = 1'b0;
    d = WIDTH'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || result_valid) && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL wait_done timeout pending %0d expected 0", exp_q.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned sum1;
    int t;
    rst = 1'b1; active_output = 1'b0; d = '0;
    idle(3);
    rst = 1'b0;
    idle(2); #1;
    check("reset_fields", actual(), '0);
    check("reset_valid", RW'(result_valid), '0);

    // full sorted frame, ready high: one-cycle valid
    ready_mode = 1;
    sum1 = sum_or_zero(4082);
    cur_w = '{3, 5, 5, 9, 10, 20, 30, 4000};
    exp_q.push_back(pack(12'd3, 12'd4000, 12'd10, 4'd8, SUMW'(sum1), 1'b0, 1'b0, 1'b0));
    send_words(); wait_done();
    check("valid_one_cycle", RW'(valid_len), RW'(1));
    idle(2);

    // out-of-order frame
    cur_w = '{1, 2, 7, 6, 8, 9, 9, 9};
    exp_q.push_back(pack(12'd1, 12'd9, 12'd8, 4'd8, SUMW'(sum_or_zero(51)), 1'b1, 1'b0, 1'b0));
    send_words(); wait_done(); idle(2);

    // truncated frame
    cur_w = '{4, 5, 6};
    exp_q.push_back(pack(12'd4, 12'd6, 12'd0, 4'd3, SUMW'(sum_or_zero(15)), 1'b0, 1'b1, 1'b0));
    send_words(); wait_done(); idle(2);

    // overrun: second frame arrives while the first is held
    ready_mode = 2;
    cur_w = '{10, 20, 30, 40, 50, 60, 70, 80};
    exp_q.push_back(model());
    send_words();
    t = 0;
    while (!result_valid && t < 50) begin @(negedge clk); #1; t++; end
    check("hold_reached", RW'(result_valid), RW'(1));
    idle(2);
    cur_w = '{1, 1, 1};
    send_words(); idle(1); #1;
    check("overrun_set", RW'(overrun), RW'(1));
    check("held_count", RW'(res_count), RW'(8));
    ready_mode = 1;
    wait_done(); idle(1); #1;
    check("overrun_clear", RW'(overrun), RW'(0));
    cur_w = '{7, 8, 9, 10, 11, 12, 13, 14};
    exp_q.push_back(model());
    send_words(); wait_done(); idle(2);

    // reset mid-frame with active_output held high
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); active_output = 1'b1; d = WIDTH'(i * 3);
    end
    @(negedge clk); rst = 1'b1; d = 12'd50;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); d = WIDTH'(100 + i);
    end
    @(negedge clk); active_output = 1'b0;
    idle(10); #1;
    check("post_reset_valid", RW'(result_valid), RW'(0));
    check("post_reset_count", RW'(res_count), RW'(0));
    cur_w = '{0, 100, 200, 300, 400, 500, 600, 4095};
    exp_q.push_back(model());
    send_words(); wait_done(); idle(2);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, SIZE + 3);
      int hi  = ($urandom_range(0, 1) == 1) ? 4095 : 15;
      cur_w.delete();
      for (int i = 0; i < len; i++) cur_w.push_back($urandom_range(0, hi));
      if ($urandom_range(0, 3) != 0) cur_w.sort();
      exp_q.push_back(model());
      send_words();
      wait_done();
      idle($urandom_range(1, 4));
    end

    wait_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
